// File: rtl/guess_sched.sv
// guess_sched: sits between the UART receiver and the game core.
//
// Each rising edge of `ready` is classified. A-Z letters are queued in a small
// FIFO. Backspace (8'h08) removes the newest queued entry. All other bytes are
// dropped. Queued letters are handed to the game one at a time as a one-cycle
// `guess_valid` pulse, and only while `game_rdy` is high.
//
// Optional build macro: GUESS_LOWER_FOLD_EN
//   When defined, lowercase a-z bytes are accepted and folded to uppercase.
//
// Ports:
//   clk         system clock
//   nRst        asynchronous active-low reset
//   ready       UART byte-available level; its rising edge marks a new byte
//   Rx_byte     received byte, sampled on the rising edge of ready
//   game_rdy    game core can accept a guess (level)
//   clr         synchronous flush of the queue and the overflow flag
//   guess       last issued letter (held between pulses)
//   guess_valid one-cycle pulse marking a new guess
//   count       current FIFO occupancy
//   overflow    sticky: an accepted letter was dropped on a full FIFO
//
// FSM states:
//   IDLE    | may pop the head into guess when count > 0 and game_rdy
//   PRESENT | guess_valid high for this cycle, then back to IDLE
module guess_sched #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          ready,
    input  logic [7:0]    Rx_byte,
    input  logic          game_rdy,
    input  logic          clr,
    output logic [7:0]    guess,
    output logic          guess_valid,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ready_q;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_guess;
    logic [7:0]    r_mem [DEPTH];

    logic          w_rx_evt;
    logic          w_is_letter;
    logic [7:0]    w_letter;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_bs;
    logic [CW-1:0] w_count_nxt;

    assign w_rx_evt = ready & ~r_ready_q;

    always_comb begin
        w_letter    = Rx_byte;
        w_is_letter = (Rx_byte >= 8'h41) && (Rx_byte <= 8'h5A);
`ifdef GUESS_LOWER_FOLD_EN
        if ((Rx_byte >= 8'h61) && (Rx_byte <= 8'h7A)) begin
            w_is_letter = 1'b1;
            w_letter    = Rx_byte - 8'h20;
        end
`endif
    end

    // Output FSM; clr forces IDLE and suppresses any pop.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!clr && (r_count != '0) && game_rdy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
        end
    end

    // A full FIFO still accepts a letter when the head leaves in the same cycle.
    assign w_push = !clr && w_rx_evt && w_is_letter && ((r_count < DEPTH_C) || w_pop);
    assign w_drop = !clr && w_rx_evt && w_is_letter && !((r_count < DEPTH_C) || w_pop);

    // With a single entry the pop takes it, so the backspace has nothing left to remove.
    assign w_bs = !clr && w_rx_evt && (Rx_byte == 8'h08) && (r_count != '0) &&
                  !(w_pop && (r_count == CW'(1)));

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop) - CW'(w_bs);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_ready_q  <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_guess    <= 8'h00;
        end else begin
            r_ready_q <= ready;
            if (clr) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_guess  <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end else if (w_bs) begin
                    r_wr_ptr <= r_wr_ptr - PW'(1);
                end
                r_count <= w_count_nxt;
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_letter;
        end
    end

    assign guess       = r_guess;
    assign guess_valid = (r_state == PRESENT);
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_guess_sched.sv
module tb_guess_sched;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          ready = 1'b0;
    logic [7:0]    Rx_byte = 8'h00;
    logic          game_rdy = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    guess;
    logic          guess_valid;
    logic [CW-1:0] count;
    logic          overflow;

    guess_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nRst(nRst), .ready(ready), .Rx_byte(Rx_byte),
        .game_rdy(game_rdy), .clr(clr), .guess(guess),
        .guess_valid(guess_valid), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain letter queue plus a flag saying a guess is on show.
    byte unsigned mq[$];
    byte unsigned expq[$];
    bit           m_ovf;
    bit           m_busy;
    bit           m_prev;
    byte unsigned m_last;
    bit           prev_gv;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit accepts(byte unsigned b);
`ifdef GUESS_LOWER_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return 1'b1;
`endif
        return (b >= 8'h41 && b <= 8'h5A);
    endfunction

    function automatic byte unsigned upcase(byte unsigned b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        expq.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_prev = 1'b0;
        m_last = 8'h00;
    endtask

    task automatic model_step();
        bit evt;
        bit pop;
        int n;
        evt    = ready && !m_prev;
        m_prev = ready;
        if (clr) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_busy = 1'b0;
            return;
        end
        n   = mq.size();
        pop = !m_busy && n > 0 && game_rdy;
        if (pop) begin
            m_last = mq.pop_front();
            expq.push_back(m_last);
        end
        if (evt && accepts(Rx_byte)) begin
            if (n < DEPTH || pop) mq.push_back(upcase(Rx_byte));
            else m_ovf = 1'b1;
        end else if (evt && Rx_byte == 8'h08 && n > 0 && !(pop && n == 1)) begin
            void'(mq.pop_back());
        end
        m_busy = pop;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (nRst) model_step();
        else model_reset();
        @(negedge clk);
        chk("count", int'(count), mq.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("guess_hold", int'(guess), int'(m_last));
    endtask

    task automatic send(byte unsigned b);
        Rx_byte = b;
        ready   = 1'b1;
        cycle();
        ready   = 1'b0;
        cycle();
    endtask

    // Monitor: every pulse must match the next expected letter, last one cycle,
    // and no expected letter may go unpresented.
    initial begin
        prev_gv = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (guess_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: guess %0h with nothing expected at %0t", guess, $time);
                end else begin
                    chk("guess_pulse", int'(guess), int'(expq.pop_front()));
                end
                chk("pulse_len", int'(prev_gv), 0);
            end
            chk("missed_pulse", expq.size(), 0);
            prev_gv = guess_valid;
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        cycle();

        // 1: reset mid-stream
        game_rdy = 1'b0;
        send(8'h41); send(8'h42); send(8'h43);
        chk("t1_count3", int'(count), 3);
        nRst = 1'b0;
        #1;
        chk("t1_rst_count", int'(count), 0);
        chk("t1_rst_gv", int'(guess_valid), 0);
        chk("t1_rst_guess", int'(guess), 0);
        chk("t1_rst_ovf", int'(overflow), 0);
        cycle(); cycle();
        nRst = 1'b1;
        game_rdy = 1'b1;
        send(8'h41);
        repeat (3) cycle();
        chk("t1_guess", int'(guess), 8'h41);

        // 2: held ready strobe
        game_rdy = 1'b0;
        Rx_byte  = 8'h42;
        ready    = 1'b1;
        repeat (5) cycle();
        ready = 1'b0;
        cycle();
        chk("t2_count1", int'(count), 1);
        game_rdy = 1'b1;
        repeat (4) cycle();
        chk("t2_guess", int'(guess), 8'h42);
        chk("t2_count0", int'(count), 0);

        // 3: backpressure and overflow
        game_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h41 + i));
        chk("t3_count4", int'(count), 4);
        chk("t3_ovf", int'(overflow), 1);
        game_rdy = 1'b1;
        repeat (10) cycle();
        chk("t3_last", int'(guess), 8'h44);

        // 4: filtering and backspace
        clr = 1'b1; cycle(); clr = 1'b0;
        game_rdy = 1'b0;
        send(8'h35); send(8'h43); send(8'h44); send(8'h08);
        chk("t4_count1", int'(count), 1);
        game_rdy = 1'b1;
        repeat (4) cycle();
        chk("t4_guess", int'(guess), 8'h43);

        // 5: push into a full FIFO on the pop cycle
        game_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
        game_rdy = 1'b1;
        Rx_byte  = 8'h46;
        ready    = 1'b1;
        cycle();
        chk("t5_count4", int'(count), 4);
        chk("t5_ovf", int'(overflow), 0);
        ready = 1'b0;
        repeat (10) cycle();

        // 6: lowercase, then clr
        send(8'h61);
        repeat (3) cycle();
        game_rdy = 1'b0;
        send(8'h41); send(8'h42);
        chk("t6_count2", int'(count), 2);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("t6_clr_count", int'(count), 0);
        chk("t6_clr_ovf", int'(overflow), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: Rx_byte = 8'($urandom_range(8'h41, 8'h5A));
                4:          Rx_byte = 8'h08;
                5:          Rx_byte = 8'($urandom_range(8'h61, 8'h7A));
                default:    Rx_byte = 8'($urandom_range(0, 255));
            endcase
            ready    = ($urandom_range(0, 2) != 0);
            game_rdy = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 999) == 0) begin
                nRst = 1'b0;
                cycle();
                nRst = 1'b1;
            end
            cycle();
        end

        ready    = 1'b0;
        clr      = 1'b0;
        game_rdy = 1'b1;
        repeat (12) cycle();
        chk("drain_count", int'(count), 0);
        chk("drain_exp", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
